// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, default latencies and a small helper.
// Imported by the decoder, the hazard unit and e_mdu.
package mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MTHI  = 4'd5;
  localparam mdu_op_t MDU_MTLO  = 4'd6;
  localparam mdu_op_t MDU_MADD  = 4'd7;
  localparam mdu_op_t MDU_MADDU = 4'd8;
  localparam mdu_op_t MDU_MSUB  = 4'd9;
  localparam mdu_op_t MDU_MSUBU = 4'd10;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic int mdu_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bundle: op request in, busy and architectural HI/LO out.
// master = pipeline side, slave = the MDU.
interface e_mdu_if;
   import mdu_pkg::*;

   logic        start;
   mdu_op_t     op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input  busy, hi, lo);
   modport slave  (input  start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models latency with a busy counter.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into HI/LO).
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
)(
   input  logic    clk,
   input  logic    reset,
   e_mdu_if.slave  mdu
);

   localparam int CNT_W = $clog2(mdu_max(MULT_CYCLES, DIV_CYCLES)) + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [63:0]      r_shadow;

   logic [63:0]      w_prod_s;
   logic [63:0]      w_prod_u;
   logic [31:0]      w_b_nz;
   logic [31:0]      w_abs_a;
   logic [31:0]      w_abs_b;
   logic [31:0]      w_mag_q;
   logic [31:0]      w_mag_r;
   logic [31:0]      w_sq;
   logic [31:0]      w_sr;
   logic [31:0]      w_uq;
   logic [31:0]      w_ur;
   logic             w_div0;
   logic             w_long;
   logic [CNT_W-1:0] w_cnt_load;
   logic [63:0]      w_res;

   // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
   assign w_prod_s = {{32{mdu.a[31]}}, mdu.a} * {{32{mdu.b[31]}}, mdu.b};
   assign w_prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

   // Divide on magnitudes, then fix signs: truncation toward zero, remainder follows dividend.
   // The divisor is forced nonzero so b==0 never reaches the operator; that case keeps HI/LO.
   assign w_div0  = (mdu.b == 32'd0);
   assign w_b_nz  = w_div0 ? 32'd1 : mdu.b;
   assign w_abs_a = mdu.a[31]  ? (32'd0 - mdu.a)  : mdu.a;
   assign w_abs_b = w_b_nz[31] ? (32'd0 - w_b_nz) : w_b_nz;
   assign w_mag_q = w_abs_a / w_abs_b;
   assign w_mag_r = w_abs_a % w_abs_b;
   assign w_sq    = (mdu.a[31] ^ w_b_nz[31]) ? (32'd0 - w_mag_q) : w_mag_q;
   assign w_sr    = mdu.a[31] ? (32'd0 - w_mag_r) : w_mag_r;
   assign w_uq    = mdu.a / w_b_nz;
   assign w_ur    = mdu.a % w_b_nz;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      w_long     = 1'b0;
      w_cnt_load = '0;
      w_res      = {r_hi, r_lo};
      case (mdu.op)
         MDU_MULT:  begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = w_prod_s; end
         MDU_MULTU: begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = w_prod_u; end
         MDU_DIV: begin
            w_long     = 1'b1;
            w_cnt_load = DIV_LOAD;
            if (!w_div0) w_res = {w_sr, w_sq};
         end
         MDU_DIVU: begin
            w_long     = 1'b1;
            w_cnt_load = DIV_LOAD;
            if (!w_div0) w_res = {w_ur, w_uq};
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = {r_hi, r_lo} + w_prod_s; end
         MDU_MADDU: begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = {r_hi, r_lo} + w_prod_u; end
         MDU_MSUB:  begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = {r_hi, r_lo} - w_prod_s; end
         MDU_MSUBU: begin w_long = 1'b1; w_cnt_load = MULT_LOAD; w_res = {r_hi, r_lo} - w_prod_u; end
`endif
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_shadow <= '0;
      end else if (r_state == ST_IDLE) begin
         if (mdu.start) begin
            if (w_long) begin
               r_shadow <= w_res;
               r_cnt    <= w_cnt_load;
               r_state  <= ST_BUSY;
            end
            if (mdu.op == MDU_MTHI) r_hi <= mdu.a;
            if (mdu.op == MDU_MTLO) r_lo <= mdu.a;
         end
      end else begin
         if (r_cnt == '0) begin
            {r_hi, r_lo} <= r_shadow;
            r_state      <= ST_IDLE;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign mdu.busy = (r_state == ST_BUSY);
   assign mdu.hi   = r_hi;
   assign mdu.lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus random ops against an arithmetic model.
// Honours MDU_MADD_EN in the same way as the design.
module tb_e_mdu;
   import mdu_pkg::*;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_latency(input mdu_op_t op);
      case (op)
         MDU_MULT, MDU_MULTU: return 5;
         MDU_DIV, MDU_DIVU:   return 10;
`ifdef MDU_MADD_EN
         MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 5;
`endif
         default: return 0;
      endcase
   endfunction

   // Architectural effect of one accepted op on the model HI/LO.
   task automatic model_commit(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     acc, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      acc = {m_hi, m_lo};
      case (op)
         MDU_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
         MDU_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; end
         MDU_DIV: if (b != 0) begin
            q = sa / sb; r = sa % sb;
            m_lo = q[31:0]; m_hi = r[31:0];
         end
         MDU_DIVU: if (b != 0) begin
            m_lo = a / b; m_hi = a % b;
         end
         MDU_MTHI: m_hi = a;
         MDU_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
         MDU_MADD:  begin p = sa * sb; {m_hi, m_lo} = acc + p; end
         MDU_MADDU: begin p = ua * ub; {m_hi, m_lo} = acc + p; end
         MDU_MSUB:  begin p = sa * sb; {m_hi, m_lo} = acc - p; end
         MDU_MSUBU: begin p = ua * ub; {m_hi, m_lo} = acc - p; end
`endif
         default: ;
      endcase
   endtask

   // Called at a negedge; issues the op this cycle and returns in the first cycle busy is low.
   task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] old_hi, old_lo;
      int lat, n;
      old_hi = m_hi;
      old_lo = m_lo;
      lat    = model_latency(op);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.op = MDU_NONE; bus.a = $urandom; bus.b = $urandom;
      model_commit(op, a, b);
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         check("hold_hi", bus.hi, old_hi);
         check("hold_lo", bus.lo, old_lo);
         n++;
         @(negedge clk);
      end
      check($sformatf("busy_len op%0d", op), 32'(n), 32'(lat));
      check($sformatf("hi op%0d", op), bus.hi, m_hi);
      check($sformatf("lo op%0d", op), bus.lo, m_lo);
   endtask

   initial begin
      mdu_op_t     rop;
      logic [31:0] ra, rb;
      int          n;

      reset = 1'b1;
      bus.start = 1'b0; bus.op = MDU_NONE; bus.a = '0; bus.b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);

      run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFFE);
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      check("multu_hi", bus.hi, 32'h0000_0001);
      check("multu_lo", bus.lo, 32'hFFFF_FFFE);

      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);
      run_op(MDU_DIVU, 32'd7, 32'd0);
      check("divu0_lo", bus.lo, 32'hFFFF_FFFD);
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("divovf_lo", bus.lo, 32'h8000_0000);
      check("divovf_hi", bus.hi, 32'h0000_0000);

      run_op(MDU_MTHI, 32'h1234_5678, 32'd0);
      check("mthi_hi", bus.hi, 32'h1234_5678);

      // MTLO issued mid-MULT must be dropped.
      bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd3; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = MDU_MTLO; bus.a = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.start = 1'b0; bus.op = MDU_NONE;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
      check("mtlo_busy_len", 32'(n + 2), 32'd5);
      check("mtlo_busy_lo", bus.lo, 32'd15);
      check("mtlo_busy_hi", bus.hi, 32'd0);
      m_hi = 32'd0; m_lo = 32'd15;

      // Reset on busy cycle 3 discards the in-flight result.
      bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd7; bus.b = 32'd9;
      @(negedge clk);
      bus.start = 1'b0; bus.op = MDU_NONE;
      repeat (2) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);
      repeat (5) @(negedge clk);
      check("no_late_hi", bus.hi, 32'd0);
      check("no_late_lo", bus.lo, 32'd0);

      // Reset and start together: op dropped.
      run_op(MDU_MTLO, 32'h0000_0099, 32'd0);
      reset = 1'b1; bus.start = 1'b1; bus.op = MDU_MTHI; bus.a = 32'h55;
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0; bus.op = MDU_NONE;
      m_hi = '0; m_lo = '0;
      check("rst_start_hi", bus.hi, 32'd0);
      check("rst_start_lo", bus.lo, 32'd0);
      check("rst_start_busy", 32'(bus.busy), 32'd0);

      run_op(MDU_MTHI, 32'd0, 32'd0);
      run_op(MDU_MTLO, 32'd5, 32'd0);
      run_op(MDU_MADD, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
      check("madd_lo", bus.lo, 32'd17);
`else
      check("madd_lo", bus.lo, 32'd5);
`endif
      check("madd_hi", bus.hi, 32'd0);

      // Back-to-back: DIVU issued in the first idle cycle after MULT.
      run_op(MDU_MULT, 32'd2, 32'd3);
      check("b2b_mult_lo", bus.lo, 32'd6);
      run_op(MDU_DIVU, 32'd100, 32'd7);
      check("b2b_divu_lo", bus.lo, 32'd14);
      check("b2b_divu_hi", bus.hi, 32'd2);

      for (int i = 0; i < 60; i++) begin
         rop = mdu_op_t'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 20);
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit of the execute stage in the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and models fixed multi-cycle latency with a busy counter. It owns the architectural HI/LO registers, and its hi/lo outputs feed the E-stage result mux for mfhi/mflo, ahead of the E/M pipeline register. The hazard unit uses start|busy to stall MDU-dependent instructions in D.

## Interface
- MULT_CYCLES, 5, busy duration for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration for div/divu (>=1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  E-stage instruction is an MDU op this cycle
- op  in  4  operation code (mdu_pkg constants)
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- busy  out  1  multi-cycle operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 are no-ops.
- Two states: IDLE and BUSY.
- The op is accepted only when start=1 and the state is IDLE. start while BUSY is ignored; the hazard unit guarantees this does not occur.
- MULT/MULTU: 64-bit signed/unsigned product, split {hi_next, lo_next}.
- DIV/DIVU: lo_next = quotient, hi_next = remainder. Signed division truncates toward zero and the remainder takes the sign of the dividend.
- b==0 for DIV/DIVU: hi/lo_next = current HI/LO (unchanged); busy still runs DIV_CYCLES.
- DIV of 0x80000000 by 0xFFFFFFFF: lo_next=0x80000000, hi_next=0.
- Results are computed at acceptance and held in shadow registers. They are committed to HI/LO on the final busy cycle's edge.
- MTHI/MTLO: write a to HI/LO on the accepting edge. busy stays 0.
- NONE and unused codes: no state change.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES))+1. It loads N-1 on acceptance and decrements in BUSY. When it is 0 in BUSY: commit, then go to IDLE.

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, counter 0, shadow registers 0.
- Op sampled at edge E0 (start=1): busy=1 in cycles 1..N. HI/LO take new values at edge EN. From cycle N+1: busy=0 and hi/lo show the result.
- MTHI/MTLO sampled at E0: the value is visible on hi/lo from cycle 1.
- A back-to-back op (start=1 in the cycle busy first reads 0) is accepted normally. The new result replaces the old one after its own latency.
- reset asserted mid-operation: the in-flight result is discarded, and all outputs return to their reset values on that edge.
- reset and start in the same cycle: reset wins and the op is dropped.
- hi/lo are registered outputs only. There is no combinational path from a/b to hi/lo.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are accepted with MULT_CYCLES latency. {hi,lo}_next = {HI,LO} ± the signed or unsigned 64-bit product, computed modulo 2^64. The accumulator base is the HI/LO value at acceptance.
- MDU_MADD_EN undefined: codes 7-10 are treated as NONE (no busy, no state change), and the accumulate datapath is not synthesized.

## Structure
- Shared package mdu_pkg:
  - op code localparams (MDU_NONE … MDU_MSUBU)
  - MULT_CYCLES/DIV_CYCLES defaults
  - the decoder, the hazard unit and e_mdu all import it.
- No sub-module. Product, quotient and remainder are computed with single-cycle operators in the acceptance logic; the busy counter models the latency.

## Test plan
- Reset then MULT a=0xFFFFFFFF b=2 -> busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> hi/lo unchanged, busy still 10 cycles.
- MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never rises. MTLO while busy -> ignored, lo unchanged.
- MULT accepted, reset asserted on busy cycle 3 -> busy=0, hi=lo=0 next cycle, and no late commit at cycle 5.
- MDU_MADD_EN defined: HI/LO=0/5, MADD a=3 b=4 -> lo=17, hi=0. Undefined: the same op -> no busy, HI/LO stay 0/5.
- Back-to-back: MULT (2×3), then DIVU (100/7) with start in the first cycle busy=0 -> lo=6 first, then lo=14, hi=2 after 10 more cycles.
